// File: rtl/mem_arbiter_if.sv
// Request/response bundle for mem_arbiter: fetch port, data port, memory port and busy flag.
// The arbiter uses the slave modport; whatever drives requests and models memory uses master.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 10
);
    // Fetch port
    logic             if_req;
    logic [ADDR-1:0]  if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [WIDTH-1:0] if_rdata;
    logic             if_flush;

    // Data port
    logic             d_req;
    logic             d_we;
    logic [ADDR-1:0]  d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [WIDTH-1:0] d_rdata;

    // Single-port memory
    logic             mem_en;
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    logic             busy;

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined single-port memory between a fetch and a data port.
// Each grant is tracked by an LAT-deep owner pipeline that routes the read data back.
module mem_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 10,
    parameter int unsigned LAT   = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        PortIf   = 1'b0,
        PortData = 1'b1
    } port_e;

    // Stages 1..LAT-1 of the owner pipeline; the final stage is excluded from busy.
    localparam logic [LAT-1:0] BusyMask = LAT'((32'd1 << (LAT - 1)) - 32'd1);

    port_e          last_grant_q, last_grant_d;
    logic           gnt_if, gnt_d;
    logic           new_vld;

    // Bit k holds the entry granted k+1 cycles ago; bit LAT-1 is the response stage.
    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] dat_q, dat_d;
    logic [LAT-1:0] st_q, st_d;
    logic [LAT-1:0] flush_kill;

    // Grant selection
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!reset) begin
            if (bus.if_req && bus.d_req) begin
                if (last_grant_q == PortData) begin
                    gnt_if = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_if = bus.if_req;
                gnt_d  = bus.d_req;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_if) begin
            last_grant_d = PortIf;
        end else if (gnt_d) begin
            last_grant_d = PortData;
        end
    end

    // Memory request mux
    always_comb begin
        bus.mem_en    = gnt_if | gnt_d;
        bus.mem_we    = gnt_d & bus.d_we;
        bus.mem_addr  = gnt_d ? bus.d_addr : bus.if_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.if_gnt    = gnt_if;
        bus.d_gnt     = gnt_d;
    end

    // A fetch granted in a flush cycle still reads memory but never enters as valid.
    always_comb begin
        new_vld    = (gnt_if && !bus.if_flush) || gnt_d;
        flush_kill = {LAT{bus.if_flush}} & ~dat_q;
        vld_d      = ((vld_q & ~flush_kill) << 1) | LAT'(new_vld);
        dat_d      = (dat_q << 1) | LAT'(gnt_d);
        st_d       = (st_q << 1) | LAT'(gnt_d && bus.d_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PortData;
            vld_q        <= '0;
            dat_q        <= '0;
            st_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_q        <= vld_d;
            dat_q        <= dat_d;
            st_q         <= st_d;
        end
    end

    // Responses come straight from the memory read port.
    always_comb begin
        bus.if_rvalid = !reset && vld_q[LAT-1] && !dat_q[LAT-1];
        bus.d_rvalid  = !reset && vld_q[LAT-1] && dat_q[LAT-1];
        bus.if_rdata  = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
        bus.busy      = !reset && (bus.mem_en || (|(vld_q & BusyMask)));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (LAT 1..4) share one stimulus stream and are compared
// every cycle against a history-based reference model, plus directed tables and sequences.
module tb_mem_arbiter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR   = 10;
    localparam int          NLAT   = 4;
    localparam int          MAXCYC = 4096;
    localparam int          MEMW   = 1 << ADDR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             mem_init;
    logic             if_req, if_flush, d_req, d_we;
    logic [ADDR-1:0]  if_addr, d_addr;
    logic [WIDTH-1:0] d_wdata;

    logic [NLAT-1:0]  if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a, mem_we_a, busy_a;
    logic [WIDTH-1:0] if_rdata_a [NLAT];
    logic [WIDTH-1:0] d_rdata_a [NLAT];
    logic [WIDTH-1:0] mem_wdata_a [NLAT];
    logic [ADDR-1:0]  mem_addr_a [NLAT];

    function automatic logic [WIDTH-1:0] init_word(int i);
        return WIDTH'(i + 3);
    endfunction

    for (genvar g = 0; g < NLAT; g++) begin : g_lat
        mem_arbiter_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();
        logic [WIDTH-1:0] mem [MEMW];
        logic [WIDTH-1:0] dly [4];

        mem_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .LAT(g + 1)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.if_flush  = if_flush;
        assign bus.d_req     = d_req;
        assign bus.d_we      = d_we;
        assign bus.d_addr    = d_addr;
        assign bus.d_wdata   = d_wdata;
        assign bus.mem_rdata = dly[g];

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < MEMW; i++) mem[i] <= init_word(i);
            end else if (bus.mem_en && bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
            end
            dly[0] <= bus.mem_en ? mem[bus.mem_addr] : 32'hBADB_AD00;
            for (int k = 1; k < 4; k++) dly[k] <= dly[k-1];
        end

        assign if_gnt_a[g]    = bus.if_gnt;
        assign d_gnt_a[g]     = bus.d_gnt;
        assign if_rvalid_a[g] = bus.if_rvalid;
        assign d_rvalid_a[g]  = bus.d_rvalid;
        assign mem_en_a[g]    = bus.mem_en;
        assign mem_we_a[g]    = bus.mem_we;
        assign busy_a[g]      = bus.busy;
        assign if_rdata_a[g]  = bus.if_rdata;
        assign d_rdata_a[g]   = bus.d_rdata;
        assign mem_wdata_a[g] = bus.mem_wdata;
        assign mem_addr_a[g]  = bus.mem_addr;
    end

    // Reference model: per-cycle event history; responses derived by looking back LAT cycles.
    typedef struct {
        bit               rst;
        bit               flush;
        bit               gi;
        bit               gd;
        bit               st;
        logic [WIDTH-1:0] rd;
    } ev_t;

    ev_t              hist [MAXCYC];
    logic [WIDTH-1:0] refmem [MEMW];
    int               cyc;
    bit               last_d;
    int               n_tests;
    int               n_fail;

    typedef struct {
        bit               ir, dr, dwe;
        logic [ADDR-1:0]  ia, da;
        logic [WIDTH-1:0] wd;
        bit               egi, egd, ewe;
        logic [ADDR-1:0]  eaddr;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(string name, int lat, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cyc=%0d: got %h, expected %h", name, lat, cyc, act, exp);
        end
    endtask

    // An entry granted at t0 survives to cycle t unless reset hits after capture or a flush
    // (fetch only) occurs in any cycle from t0 to t-1.
    function automatic bit alive(int t0, int t, bit is_if);
        for (int c = t0; c < t; c++) begin
            if (c > t0 && hist[c].rst) return 1'b0;
            if (is_if && hist[c].flush) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        bit   gi, gd, ei, ed, eb;
        int   lat;
        ev_t  e;
        @(negedge clk);
        gi = 1'b0;
        gd = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
                gi = last_d;
                gd = !last_d;
            end else begin
                gi = if_req;
                gd = d_req;
            end
        end
        hist[cyc].rst   = reset;
        hist[cyc].flush = if_flush;
        hist[cyc].gi    = gi;
        hist[cyc].gd    = gd;
        hist[cyc].st    = gd && d_we;
        hist[cyc].rd    = gi ? refmem[if_addr] : refmem[d_addr];
        for (int g = 0; g < NLAT; g++) begin
            lat = g + 1;
            chk("if_gnt", lat, 32'(if_gnt_a[g]), 32'(gi));
            chk("d_gnt", lat, 32'(d_gnt_a[g]), 32'(gd));
            chk("mem_en", lat, 32'(mem_en_a[g]), 32'(gi | gd));
            chk("mem_we", lat, 32'(mem_we_a[g]), 32'(gd & d_we));
            if (gi || gd) chk("mem_addr", lat, 32'(mem_addr_a[g]), 32'(gi ? if_addr : d_addr));
            if (gd && d_we) chk("mem_wdata", lat, mem_wdata_a[g], d_wdata);
            ei = 1'b0;
            ed = 1'b0;
            if (!reset && cyc >= lat) begin
                e  = hist[cyc-lat];
                ei = e.gi && alive(cyc - lat, cyc, 1'b1);
                ed = e.gd && alive(cyc - lat, cyc, 1'b0);
                if (ei) chk("if_rdata", lat, if_rdata_a[g], e.rd);
                if (ed && !e.st) chk("d_rdata", lat, d_rdata_a[g], e.rd);
            end
            chk("if_rvalid", lat, 32'(if_rvalid_a[g]), 32'(ei));
            chk("d_rvalid", lat, 32'(d_rvalid_a[g]), 32'(ed));
            eb = gi || gd;
            for (int k = 1; k < lat; k++) begin
                if (cyc >= k && (hist[cyc-k].gi || hist[cyc-k].gd) &&
                    alive(cyc - k, cyc, hist[cyc-k].gi)) eb = 1'b1;
            end
            chk("busy", lat, 32'(busy_a[g]), 32'(eb && !reset));
        end
        if (reset) last_d = 1'b1;
        else if (gi) last_d = 1'b0;
        else if (gd) last_d = 1'b1;
        if (gd && d_we) refmem[d_addr] = d_wdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        if_flush = 1'b0;
        if_addr  = '0;
        d_addr   = '0;
        d_wdata  = '0;
    endtask

    int pulses;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        last_d  = 1'b1;
        for (int i = 0; i < MEMW; i++) refmem[i] = init_word(i);

        //         ir    dr    dwe   ia        da        wd             egi   egd   ewe   eaddr
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 10'h100, 10'h200, 32'h0,         1'b1, 1'b0, 1'b0, 10'h100};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 10'h104, 10'h204, 32'h0,         1'b0, 1'b1, 1'b0, 10'h204};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 10'h108, 10'h208, 32'h0,         1'b1, 1'b0, 1'b0, 10'h108};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 10'h10C, 10'h20C, 32'h0,         1'b0, 1'b1, 1'b0, 10'h20C};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 10'h110, 10'h210, 32'h0,         1'b1, 1'b0, 1'b0, 10'h110};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 10'h114, 10'h214, 32'h0,         1'b0, 1'b1, 1'b0, 10'h214};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 10'h000, 10'h020, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 10'h020};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 32'h0,         1'b0, 1'b0, 1'b0, 10'h000};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h020, 32'h0,         1'b0, 1'b1, 1'b0, 10'h020};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 10'h010, 10'h000, 32'h0,         1'b1, 1'b0, 1'b0, 10'h010};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 10'h040, 10'h044, 32'h0,         1'b0, 1'b1, 1'b0, 10'h044};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 10'h048, 10'h04C, 32'h0,         1'b1, 1'b0, 1'b0, 10'h048};

        idle_inputs();
        reset    = 1'b1;
        mem_init = 1'b1;
        @(posedge clk);
        #1;
        tick();
        mem_init = 1'b0;
        // Requests during reset are never granted.
        if_req = 1'b1;
        d_req  = 1'b1;
        #2;
        chk("rst_if_gnt", 1, 32'(if_gnt_a[0]), 32'd0);
        chk("rst_mem_en", 1, 32'(mem_en_a[0]), 32'd0);
        chk("rst_busy", 1, 32'(busy_a[0]), 32'd0);
        tick();

        // Directed table, first row lands in the first cycle out of reset.
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if_req  = tbl[i].ir;
            d_req   = tbl[i].dr;
            d_we    = tbl[i].dwe;
            if_addr = tbl[i].ia;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].wd;
            #2;
            chk("tbl_if_gnt", 1, 32'(if_gnt_a[0]), 32'(tbl[i].egi));
            chk("tbl_d_gnt", 1, 32'(d_gnt_a[0]), 32'(tbl[i].egd));
            chk("tbl_mem_we", 1, 32'(mem_we_a[0]), 32'(tbl[i].ewe));
            if (tbl[i].egi || tbl[i].egd)
                chk("tbl_mem_addr", 1, 32'(mem_addr_a[0]), 32'(tbl[i].eaddr));
            if (i == 7) chk("tbl_store_ack", 1, 32'(d_rvalid_a[0]), 32'd1);
            if (i == 9) begin
                chk("tbl_load_vld", 1, 32'(d_rvalid_a[0]), 32'd1);
                chk("tbl_load_data", 1, d_rdata_a[0], 32'hDEADBEEF);
            end
            tick();
        end
        idle_inputs();
        repeat (5) tick();

        // Single fetch on LAT=1.
        if_req  = 1'b1;
        if_addr = 10'h010;
        #2;
        chk("fetch1_gnt", 1, 32'(if_gnt_a[0]), 32'd1);
        tick();
        idle_inputs();
        #2;
        chk("fetch1_rvalid", 1, 32'(if_rvalid_a[0]), 32'd1);
        chk("fetch1_rdata", 1, if_rdata_a[0], 32'h00000013);
        chk("fetch1_d_rvalid", 1, 32'(d_rvalid_a[0]), 32'd0);
        tick();
        repeat (4) tick();

        // Flush of three back-to-back fetches on LAT=3, then a fresh fetch.
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (c < 3) begin
                if_req  = 1'b1;
                if_addr = 10'(c * 4);
            end
            if (c == 2) if_flush = 1'b1;
            if (c == 3) begin
                if_req  = 1'b1;
                if_addr = 10'h040;
            end
            #2;
            if (c == 6) begin
                chk("flush_new_rvalid", 3, 32'(if_rvalid_a[2]), 32'd1);
                chk("flush_new_rdata", 3, if_rdata_a[2], init_word(32'h40));
            end else begin
                pulses += int'(if_rvalid_a[2]);
            end
            tick();
        end
        chk("flush_pulses", 3, 32'(pulses), 32'd0);
        idle_inputs();
        repeat (5) tick();

        // Reset one cycle after a load grant on LAT=2.
        d_req  = 1'b1;
        d_addr = 10'h030;
        #2;
        chk("rstmid_gnt", 2, 32'(d_gnt_a[1]), 32'd1);
        tick();
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("rstmid_rvalid_in", 2, 32'(d_rvalid_a[1]), 32'd0);
        chk("rstmid_busy_in", 2, 32'(busy_a[1]), 32'd0);
        tick();
        reset = 1'b0;
        #2;
        chk("rstmid_rvalid_out", 2, 32'(d_rvalid_a[1]), 32'd0);
        chk("rstmid_busy_out", 2, 32'(busy_a[1]), 32'd0);
        tick();
        repeat (3) tick();
        // Last grant was fetch before reset; reset must return arbitration to fetch-first.
        if_req  = 1'b1;
        if_addr = 10'h0A0;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 10'h0A4;
        d_addr  = 10'h0A8;
        #2;
        chk("rst_last_grant", 2, 32'(if_gnt_a[1]), 32'd1);
        tick();
        idle_inputs();
        repeat (5) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 99) < 2);
            if_req   = ($urandom_range(0, 99) < 60);
            d_req    = ($urandom_range(0, 99) < 50);
            d_we     = ($urandom_range(0, 99) < 40);
            if_flush = ($urandom_range(0, 99) < 10);
            if_addr  = 10'($urandom_range(0, 31) * 4);
            d_addr   = 10'($urandom_range(0, 31) * 4);
            d_wdata  = $urandom;
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/word width.
REQ-002 SHALL have parameter ADDR, default 10, memory byte-address width.
REQ-003 SHALL have parameter LAT, default 1, legal 1..4, fixed memory read latency in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch request, held until granted.
REQ-007 if_addr  input  ADDR  fetch address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  WIDTH  fetch read data.
REQ-011 if_flush  input  1  discard all in-flight fetch responses (branch/jump taken).
REQ-012 d_req  input  1  data request, held until granted.
REQ-013 d_we  input  1  1 = store, 0 = load.
REQ-014 d_addr  input  ADDR  data address.
REQ-015 d_wdata  input  WIDTH  store data.
REQ-016 d_gnt  output  1  data request accepted this cycle.
REQ-017 d_rvalid  output  1  load data valid or store acknowledge.
REQ-018 d_rdata  output  WIDTH  load data.
REQ-019 mem_en, mem_we  output  1 each  single-port memory enable / write enable.
REQ-020 mem_addr  output  ADDR; mem_wdata  output  WIDTH; mem_rdata  input  WIDTH, valid LAT cycles after mem_en.
REQ-021 busy  output  1  at least one response in flight.

Function
REQ-022 At most one of if_gnt, d_gnt SHALL be 1 per cycle; grants are combinational from requests and arbiter state.
REQ-023 Requester alone -> granted same cycle; both requesting -> round-robin: grant the port NOT granted most recently (last_grant register).
REQ-024 last_grant SHALL update only on a grant; reset value = DATA, so the first contested cycle grants fetch.
REQ-025 On a grant, mem_en=1 same cycle with mem_addr/mem_we/mem_wdata from the granted port; mem_we=0 for fetch; mem_en=0 and mem_we=0 when no grant.
REQ-026 Back-to-back grants every cycle SHALL be supported (memory fully pipelined).
REQ-027 An LAT-stage owner pipeline SHALL record per grant {valid, port, is_store}; stage LAT output drives responses.
REQ-028 Fetch response: if_rvalid=1 and if_rdata=mem_rdata exactly LAT cycles after if_gnt.
REQ-029 Data load: d_rvalid=1 and d_rdata=mem_rdata exactly LAT cycles after d_gnt; store: d_rvalid=1 at LAT cycles after d_gnt, d_rdata don't-care.
REQ-030 if_rdata/d_rdata SHALL be driven from mem_rdata (no extra register); values outside rvalid are don't-care.
REQ-031 if_flush=1 SHALL clear valid on every in-flight fetch entry in the owner pipeline, including a fetch granted in the same cycle; data entries unaffected.
REQ-032 Flush SHALL NOT block granting: a fetch requested in the cycle after flush is granted and responded normally.
REQ-033 busy SHALL equal OR of valid bits across owner pipeline stages 1..LAT-1 plus any grant this cycle.
REQ-034 Request signals dropped before grant are legal; no memory access, no response.
REQ-035 Simultaneous flush and data grant: data entry proceeds; simultaneous flush and fetch grant: fetch memory read issued but response suppressed.

Reset
REQ-036 While reset=1: if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, busy SHALL be 0; all owner pipeline valid bits cleared; last_grant=DATA.
REQ-037 Reset mid-operation SHALL discard all in-flight responses; no rvalid pulse in the cycles following deassertion for pre-reset grants.
REQ-038 First grant possible in the first cycle with reset=0.

Verification
REQ-039 LAT=1, only if_req at addr 0x010, mem returns 0x00000013 -> if_gnt cycle 0, if_rvalid with if_rdata=0x00000013 cycle 1, d_rvalid=0 throughout.
REQ-040 Both requesting continuously for 6 cycles after reset -> grants alternate IF,D,IF,D,IF,D; mem_addr tracks granted port each cycle.
REQ-041 d_req store addr 0x020 data 0xDEADBEEF, then load 0x020 -> mem_we=1 with wdata 0xDEADBEEF; d_rvalid ack after LAT; load returns 0xDEADBEEF.
REQ-042 LAT=3, fetches at 0x0,0x4,0x8 back-to-back, if_flush pulsed in cycle 2 -> zero if_rvalid pulses for all three; fetch at 0x40 in cycle 3 returns in cycle 6.
REQ-043 LAT=2, reset asserted one cycle after a load grant -> no d_rvalid after reset; busy=0, last_grant=DATA (next contested grant = IF).
REQ-044 Random traffic, all LAT values -> scoreboard: every accepted request yields exactly one response in order per port, never both grants in one cycle.
